// File: rtl/aes_inv_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aes_inv_core                                                 |
// | Description : Iterative AES-128 decryption core. The key schedule is run   |
// |               forward once to reach the last round key, which is then      |
// |               unwound one step per round alongside the state datapath.     |
// | Ports       : clk      - rising-edge clock                                 |
// |               reset    - asynchronous active-high reset                    |
// |               start    - decrypt request, sampled only while idle          |
// |               data_in  - 128-bit ciphertext (byte 0 in [127:120])          |
// |               key      - 128-bit cipher key, same byte order               |
// |               busy     - high whenever the core is not idle                |
// |               done     - one-cycle pulse when data_out is updated          |
// |               data_out - 128-bit plaintext, held until next completion     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module aes_inv_core (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] data_in,
   input  logic [127:0] key,
   output logic         busy,
   output logic         done,
   output logic [127:0] data_out
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_KEXP  = 3'd1;
   localparam logic [2:0] S_ADD   = 3'd2;
   localparam logic [2:0] S_ROUND = 3'd3;
   localparam logic [2:0] S_FINAL = 3'd4;

   logic [2:0]   fsm;
   logic [3:0]   rnd;
   logic [127:0] st;
   logic [127:0] rkey;

   // ---------------- GF(2^8) helpers ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128 (0 maps to 0).
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] r;
      sq = a;
      r  = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r;
   endfunction

   // S-boxes built from the inverse plus the FIPS-197 affine map (and its inverse).
   function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // ---------------- State datapath ----------------
   logic [127:0] sr_sub;   // InvSubBytes(InvShiftRows(st))
   logic [127:0] rk_add;   // ... ^ current round key
   logic [127:0] mixed;    // InvMixColumns of the above

   // Byte i sits at row i%4, column i/4; inverse shift moves row r right by r.
   for (genvar i = 0; i < 16; i++) begin : g_inv_sub
      localparam int ROW = i % 4;
      localparam int COL = i / 4;
      localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
      assign sr_sub[127-8*i -: 8] = inv_sbox(st[127-8*SRC -: 8]);
   end

   assign rk_add = sr_sub ^ rkey;

   for (genvar c = 0; c < 4; c++) begin : g_inv_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = rk_add[127-32*c -: 8];
      assign a1 = rk_add[119-32*c -: 8];
      assign a2 = rk_add[111-32*c -: 8];
      assign a3 = rk_add[103-32*c -: 8];
      assign mixed[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      assign mixed[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      assign mixed[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      assign mixed[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
   end

   // ---------------- Key schedule (forward and inverse share SubWord) ----------------
   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  sw_in, sw, rc_word, fk0;
   logic [3:0]   rc_idx;
   logic [127:0] key_fwd, key_inv;

   assign {w0, w1, w2, w3} = rkey;
   // Forward step rotates w3; inverse step rotates the recovered previous w3 (= w2^w3).
   assign sw_in   = (fsm == S_KEXP) ? w3 : (w2 ^ w3);
   assign sw      = {fwd_sbox(sw_in[23:16]), fwd_sbox(sw_in[15:8]),
                     fwd_sbox(sw_in[7:0]),   fwd_sbox(sw_in[31:24])};
   // rnd has already advanced to 11 in ADD, where the k10->k9 step needs rcon(10).
   assign rc_idx  = (fsm == S_ADD) ? 4'd10 : rnd;
   assign rc_word = {rcon(rc_idx), 24'h000000};
   assign fk0     = w0 ^ sw ^ rc_word;
   assign key_fwd = {fk0, w1 ^ fk0, w2 ^ w1 ^ fk0, w3 ^ w2 ^ w1 ^ fk0};
   assign key_inv = {w0 ^ sw ^ rc_word, w0 ^ w1, w1 ^ w2, w2 ^ w3};

   // ---------------- Control ----------------
   assign busy = (fsm != S_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm      <= S_IDLE;
         rnd      <= 4'd0;
         st       <= 128'h0;
         rkey     <= 128'h0;
         data_out <= 128'h0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (fsm)
            S_IDLE: begin
               if (start) begin
                  st   <= data_in;
                  rkey <= key;
                  rnd  <= 4'd1;
                  fsm  <= S_KEXP;
               end
            end
            S_KEXP: begin
               rkey <= key_fwd;
               rnd  <= rnd + 4'd1;
               if (rnd == 4'd10) fsm <= S_ADD;
            end
            S_ADD: begin
               st   <= st ^ rkey;
               rkey <= key_inv;
               rnd  <= 4'd9;
               fsm  <= S_ROUND;
            end
            S_ROUND: begin
               st   <= mixed;
               rkey <= key_inv;
               rnd  <= rnd - 4'd1;
               if (rnd == 4'd1) fsm <= S_FINAL;
            end
            S_FINAL: begin
               data_out <= rk_add;
               done     <= 1'b1;
               fsm      <= S_IDLE;
            end
            default: fsm <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
